bist_session_ctrl: RTL
======================

BIST_SESSION_CTRL -- requirements
Module: bist_session_ctrl

Interface
REQ-001 SHALL have parameter N_RUNS, default 4: number of back-to-back BIST sessions per request (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for any bist_end edge.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port go, input, 1: one-cycle request to start a campaign.
REQ-006 SHALL have port abort, input, 1: synchronous campaign cancel.
REQ-007 SHALL have port bist_end, input, 1: level end-of-session flag from the BIST top.
REQ-008 SHALL have port pass_fail, input, 1: session verdict, valid while bist_end=1 (1=pass).
REQ-009 SHALL have port bist_start, output, 1: registered one-cycle start pulse to the BIST top.
REQ-010 SHALL have port busy, output, 1: high from the cycle after an accepted go until DONE or IDLE is re-entered.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at campaign completion.
REQ-012 SHALL have port run_idx, output, 8: index of the current or last session (0-based).
REQ-013 SHALL have port fail_cnt, output, 8: failing sessions in the campaign.
REQ-014 SHALL have port result_ok, output, 1: 1 when the last campaign had fail_cnt=0 and no timeout; held until the next go.
REQ-015 SHALL have port timeout_err, output, 1: sticky flag for a watchdog expiry; cleared by the next accepted go.

Function
REQ-016 SHALL implement the states IDLE, START, WAIT_END, WAIT_LOW and DONE.
REQ-017 IDLE: go=1 and abort=0 SHALL go to START; clear fail_cnt, run_idx, result_ok and timeout_err; restart the watchdog.
REQ-018 START: bist_start SHALL be 1 for exactly this one cycle; next state WAIT_END.
REQ-019 WAIT_END: the first cycle with bist_end=1 SHALL sample pass_fail; fail_cnt SHALL increment when pass_fail=0; next state WAIT_LOW.
REQ-020 WAIT_LOW: when bist_end=0, if run_idx=N_RUNS-1 the next state SHALL be DONE; otherwise run_idx SHALL increment and the next state SHALL be START.
REQ-021 DONE: done SHALL be 1 for one cycle; result_ok SHALL be (fail_cnt==0 && !timeout_err); next state IDLE.
REQ-022 The watchdog SHALL restart on entry to WAIT_END and to WAIT_LOW; reaching TIMEOUT cycles in either state SHALL set timeout_err and go to DONE.
REQ-023 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, with no done pulse, with counters held and result_ok=0.
REQ-024 Ties: abort SHALL beat go and beat a bist_end edge in the same cycle; go SHALL be ignored while busy=1.
REQ-025 bist_end=1 already present on entry to WAIT_END SHALL be treated as an edge (sampled immediately).
REQ-026 fail_cnt SHALL saturate at 255 and SHALL never wrap.
REQ-027 Latency: go to bist_start SHALL be 1 cycle; bist_end fall to the next bist_start SHALL be 2 cycles.

Reset
REQ-028 RST=0 SHALL asynchronously force IDLE, bist_start=0, busy=0, done=0, run_idx=0, fail_cnt=0, result_ok=0, timeout_err=0 and watchdog=0.
REQ-029 Reset mid-campaign SHALL discard all progress; after release, the block SHALL wait in IDLE for go.

Structure
REQ-030 State encodings and default constants (N_RUNS, TIMEOUT, counter width 8) SHALL live in shared package bist_pkg.
REQ-031 The watchdog SHALL be a sub-module bist_wdog (inputs: clear and enable; output: expired; parameter TIMEOUT).
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-033 N_RUNS=4, each session pass_fail=1 with bist_end high for 3 cycles -> 4 bist_start pulses, done once, fail_cnt=0, result_ok=1.
REQ-034 N_RUNS=4, sessions 1 and 3 return pass_fail=0 -> fail_cnt=2, result_ok=0, run_idx=3 at done.
REQ-035 TIMEOUT=16, bist_end never rises -> timeout_err=1 at cycle 16 of WAIT_END, done pulses, result_ok=0, only 1 bist_start.
REQ-036 abort in cycle 2 of WAIT_END of session 2 -> IDLE next cycle, no done, busy=0; a later go restarts with run_idx=0.
REQ-037 go and abort in the same IDLE cycle -> no bist_start; go during busy -> ignored, with the bist_start count unchanged.
REQ-038 RST low mid-WAIT_LOW -> all outputs at reset values within the same cycle, independent of CLK.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared encodings, default constants and helpers for the BIST session controller.
package bist_pkg;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned N_RUNS_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_END = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Saturating increment so the failure counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bist_wdog.sv
// Cycle watchdog: counts enabled cycles since the last clear, flags TIMEOUT reached.
module bist_wdog
    import bist_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;
    logic          expired_q, expired_d;

    // expired_q mirrors count_q, so a state entering at count 0 times out on its TIMEOUT-th cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired_q) begin
            count_d = count_q + CW'(1);
        end
        expired_d = (count_d >= CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/bist_session_ctrl.sv
// Sequences N_RUNS back-to-back BIST sessions per go, tallies failures and guards each wait.
module bist_session_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned N_RUNS  = N_RUNS_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             go,
    input  logic             abort,
    input  logic             bist_end,
    input  logic             pass_fail,
    output logic             bist_start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] run_idx,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             result_ok,
    output logic             timeout_err
);

    state_e           state_q, state_d;
    logic             bist_end_q, pass_q;
    logic             bist_start_q, bist_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] run_idx_q, run_idx_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             result_ok_q, result_ok_d;
    logic             timeout_err_q, timeout_err_d;
    logic             wd_clear, wd_enable, wd_expired;

    always_comb begin
        state_d       = state_q;
        run_idx_d     = run_idx_q;
        fail_cnt_d    = fail_cnt_q;
        result_ok_d   = result_ok_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (go && !abort) begin
                    state_d       = ST_START;
                    run_idx_d     = '0;
                    fail_cnt_d    = '0;
                    result_ok_d   = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_START: state_d = ST_WAIT_END;
            ST_WAIT_END: begin
                // A level already high on entry counts as the end edge.
                if (bist_end_q) begin
                    if (!pass_q) begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end
                    state_d = ST_WAIT_LOW;
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_WAIT_LOW: begin
                if (!bist_end_q) begin
                    if (run_idx_q == CNT_W'(N_RUNS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        run_idx_d = run_idx_q + CNT_W'(1);
                        state_d   = ST_START;
                    end
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_DONE) begin
            result_ok_d = (fail_cnt_d == '0) && !timeout_err_d;
        end

        // Abort wins over every other event and freezes the campaign counters.
        if (abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            run_idx_d     = run_idx_q;
            fail_cnt_d    = fail_cnt_q;
            timeout_err_d = timeout_err_q;
            result_ok_d   = 1'b0;
        end

        bist_start_d = (state_d == ST_START);
        busy_d       = (state_d == ST_START) || (state_d == ST_WAIT_END) || (state_d == ST_WAIT_LOW);
        done_d       = (state_d == ST_DONE);
        wd_clear     = (state_d != state_q);
        wd_enable    = (state_q == ST_WAIT_END) || (state_q == ST_WAIT_LOW);
    end

    // bist_end/pass_fail pass through an input flop, giving the 2-cycle fall-to-start latency.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            bist_end_q    <= 1'b0;
            pass_q        <= 1'b0;
            bist_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            run_idx_q     <= '0;
            fail_cnt_q    <= '0;
            result_ok_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bist_end_q    <= bist_end;
            pass_q        <= pass_fail;
            bist_start_q  <= bist_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            run_idx_q     <= run_idx_d;
            fail_cnt_q    <= fail_cnt_d;
            result_ok_q   <= result_ok_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    bist_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (CLK),
        .rst_n   (RST),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign bist_start  = bist_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign run_idx     = run_idx_q;
    assign fail_cnt    = fail_cnt_q;
    assign result_ok   = result_ok_q;
    assign timeout_err = timeout_err_q;

endmodule
